// File: rtl/obf_key_if.sv
// Handshake/bus bundle between the key source and obf_key_loader.
// The zeroize wire exists only when OBF_KEY_ZEROIZE_EN is defined.
interface obf_key_if #(
   parameter int KEY_W = 12
) ();
   logic             start;
   logic             ser_valid;
   logic             ser_data;
   logic             ser_ready;
   logic             clear;
   logic [KEY_W-1:0] key_out;
   logic             armed;
   logic             busy;
   logic             err;
   logic             locked;
   logic [3:0]       fail_cnt;
`ifdef OBF_KEY_ZEROIZE_EN
   logic             zeroize;

   modport master (
      output start, ser_valid, ser_data, clear, zeroize,
      input  ser_ready, key_out, armed, busy, err, locked, fail_cnt
   );
   modport slave (
      input  start, ser_valid, ser_data, clear, zeroize,
      output ser_ready, key_out, armed, busy, err, locked, fail_cnt
   );
`else
   modport master (
      output start, ser_valid, ser_data, clear,
      input  ser_ready, key_out, armed, busy, err, locked, fail_cnt
   );
   modport slave (
      input  start, ser_valid, ser_data, clear,
      output ser_ready, key_out, armed, busy, err, locked, fail_cnt
   );
`endif
endinterface

// File: rtl/obf_key_loader.sv
// Serial key loader for a key-obfuscated netlist: validates a folded-XOR checksum
// before exposing the key. Optional zeroize input enabled by OBF_KEY_ZEROIZE_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start, lock pattern driven
// S_LOAD    | shifting in key bits then checksum bits
// S_CHECK   | one cycle: compare folded key against received checksum
// S_ARMED   | validated key driven on key_out
// S_ERROR   | bad frame seen, waiting for clear
// S_LOCKOUT | too many bad frames, sticky until rst
module obf_key_loader #(
   parameter int         NUM_SITES = 6,
   parameter int         KEY_W     = 2*NUM_SITES,
   parameter int         CHK_W     = 4,
   parameter int         MAX_FAIL  = 3,
   parameter logic [1:0] LOCK_SITE = 2'b11
) (
   input logic      clk,
   input logic      rst,
   obf_key_if.slave bus
);
   localparam int TOT    = KEY_W + CHK_W;
   localparam int CNT_W  = $clog2(TOT + 1);
   localparam int NCHUNK = (KEY_W + CHK_W - 1) / CHK_W;
   localparam logic [KEY_W-1:0] LOCK_KEY = {NUM_SITES{LOCK_SITE}};

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CHECK, S_ARMED, S_ERROR, S_LOCKOUT
   } state_t;

   state_t           state;
   logic [KEY_W-1:0] shadow;
   logic [CHK_W-1:0] rx_chk;
   logic [CNT_W-1:0] bit_cnt;
   logic [KEY_W-1:0] key_q;
   logic [3:0]       fail_cnt;
   logic [3:0]       fail_nxt;
   logic             armed, busy, err, locked, ser_ready;

   // top chunk is zero-padded when KEY_W is not a multiple of CHK_W
   function automatic logic [CHK_W-1:0] fold(input logic [KEY_W-1:0] k);
      logic [NCHUNK*CHK_W-1:0] p;
      logic [CHK_W-1:0]        acc;
      p            = '0;
      p[KEY_W-1:0] = k;
      acc          = '0;
      for (int i = 0; i < NCHUNK; i++) acc ^= p[i*CHK_W +: CHK_W];
      return acc;
   endfunction

   assign fail_nxt = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         shadow    <= '0;
         rx_chk    <= '0;
         bit_cnt   <= '0;
         key_q     <= LOCK_KEY;
         fail_cnt  <= 4'd0;
         armed     <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         locked    <= 1'b0;
         ser_ready <= 1'b0;
      end else begin
`ifdef OBF_KEY_ZEROIZE_EN
         if (bus.zeroize) begin
            shadow  <= '0;
            rx_chk  <= '0;
            bit_cnt <= '0;
            key_q   <= LOCK_KEY;
            armed   <= 1'b0;
            if (state != S_LOCKOUT) begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               err       <= 1'b0;
               ser_ready <= 1'b0;
            end
         end else
`endif
         begin
            case (state)
               S_IDLE, S_ARMED: begin
                  if (bus.start) begin
                     state     <= S_LOAD;
                     bit_cnt   <= '0;
                     armed     <= 1'b0;
                     key_q     <= LOCK_KEY;
                     busy      <= 1'b1;
                     ser_ready <= 1'b1;
                     if (state == S_ARMED) shadow <= '0;
                  end
               end
               S_LOAD: begin
                  if (bus.ser_valid && ser_ready) begin
                     for (int i = 0; i < KEY_W; i++)
                        if (bit_cnt == CNT_W'(i)) shadow[i] <= bus.ser_data;
                     for (int i = 0; i < CHK_W; i++)
                        if (bit_cnt == CNT_W'(KEY_W + i)) rx_chk[i] <= bus.ser_data;
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == CNT_W'(TOT - 1)) begin
                        state     <= S_CHECK;
                        ser_ready <= 1'b0;
                     end
                  end
               end
               S_CHECK: begin
                  busy <= 1'b0;
                  if (fold(shadow) == rx_chk) begin
                     state <= S_ARMED;
                     key_q <= shadow;
                     armed <= 1'b1;
                  end else begin
                     fail_cnt <= fail_nxt;
                     shadow   <= '0;
                     if (fail_nxt >= 4'(MAX_FAIL)) begin
                        state  <= S_LOCKOUT;
                        locked <= 1'b1;
                     end else begin
                        state <= S_ERROR;
                        err   <= 1'b1;
                     end
                  end
               end
               S_ERROR: begin
                  if (bus.clear) begin
                     state <= S_IDLE;
                     err   <= 1'b0;
                  end
               end
               S_LOCKOUT: state <= S_LOCKOUT;
               default:   state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.key_out   = key_q;
   assign bus.armed     = armed;
   assign bus.busy      = busy;
   assign bus.err       = err;
   assign bus.locked    = locked;
   assign bus.fail_cnt  = fail_cnt;
   assign bus.ser_ready = ser_ready;
endmodule
